// File: rtl/dsm_pkg.sv
// Shared constants, state encoding and fraction lookup for the DSM channel-hop path.
package dsm_pkg;

   localparam int          NUM_CH_DEF = 79;
   localparam int          BASE_CONST = 16;
   localparam logic [23:0] RST_FRAC   = 24'h333333;

   // round(r * 2^24 / 10) for r = 0..9
   localparam logic [23:0] FRAC_LUT [10] = '{
      24'h000000, 24'h19999A, 24'h333333, 24'h4CCCCD, 24'h666666,
      24'h800000, 24'h99999A, 24'hB33333, 24'hCCCCCD, 24'hE66666
   };

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      CALC      = 2'd1,
      WAIT_TICK = 2'd2,
      SETTLE    = 2'd3
   } state_t;

   // Remainder-to-fraction lookup; remainders above 9 cannot occur and map to zero.
   function automatic logic [23:0] frac_of(input logic [3:0] r);
      logic [23:0] f;
      f = 24'h000000;
      if (r <= 4'd9) f = FRAC_LUT[r];
      return f;
   endfunction

endpackage

// File: rtl/chan_div10.sv
// Sequential divide-by-10 by repeated subtraction. One subtraction per cycle;
// done is asserted combinationally in the cycle the remainder drops below 10,
// so a divide takes q+1 cycles after start.
module chan_div10 (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [6:0] n_in,
   output logic       done,
   output logic [3:0] q,
   output logic [3:0] r
);

   logic [6:0] n_q;
   logic [3:0] q_q;
   logic       active;

   // Load on start, then subtract 10 per cycle until the remainder is below 10.
   always_ff @(posedge clk) begin
      if (rst) begin
         n_q    <= 7'd0;
         q_q    <= 4'd0;
         active <= 1'b0;
      end else if (start) begin
         n_q    <= n_in;
         q_q    <= 4'd0;
         active <= 1'b1;
      end else if (active) begin
         if (n_q >= 7'd10) begin
            n_q <= n_q - 7'd10;
            q_q <= q_q + 4'd1;
         end else begin
            active <= 1'b0;
         end
      end
   end

   assign done = active && (n_q < 7'd10);
   assign q    = q_q;
   assign r    = n_q[3:0];

endmodule

// File: rtl/dsm_chan_ctrl.sv
// Channel-hop controller: accepts a channel request, derives the DSM fraction
// and divider constant with a sequential divide-by-10, applies both on a DSM
// update strobe, then times a settle window.
//
// Request handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; req_ready is high only in IDLE, and a requester that
// sees req_ready low must keep req_valid and req_ch stable until the transfer.
module dsm_chan_ctrl
   import dsm_pkg::*;
#(
   parameter int NUM_CH     = NUM_CH_DEF,
   parameter int FRAC_W     = 24,
   parameter int CONST_W    = 8,
   parameter int SETTLE_CYC = 1024,
   parameter int CNT_W      = 11
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_valid,
   input  logic [6:0]         req_ch,
   output logic               req_ready,
   input  logic               dsm_tick,
   output logic [FRAC_W-1:0]  dsm_in,
   output logic [CONST_W-1:0] add_const,
   output logic [6:0]         cur_ch,
   output logic               busy,
   output logic               settled,
   output logic               err_range
);

   state_t state, state_n;

   logic [6:0]         ch_q;
   logic [FRAC_W-1:0]  shadow_frac;
   logic [CONST_W-1:0] shadow_const;
   logic [CNT_W-1:0]   cnt;

   logic       req_bad;
   logic       div_start;
   logic       div_done;
   logic [3:0] div_q;
   logic [3:0] div_r;
   logic       capture;
   logic       apply;
   logic       err_n;

   assign req_bad = ({1'b0, req_ch} >= 8'(NUM_CH));

   chan_div10 u_div (
      .clk   (clk),
      .rst   (rst),
      .start (div_start),
      .n_in  (req_ch + 7'd2),
      .done  (div_done),
      .q     (div_q),
      .r     (div_r)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // Next-state and per-cycle control strobes.
   always_comb begin
      state_n   = state;
      div_start = 1'b0;
      capture   = 1'b0;
      apply     = 1'b0;
      err_n     = 1'b0;
      case (state)
         IDLE: begin
            if (req_valid) begin
               if (req_bad) begin
                  err_n = 1'b1;
               end else begin
                  div_start = 1'b1;
                  state_n   = CALC;
               end
            end
         end
         CALC: begin
            if (div_done) begin
               capture = 1'b1;
               state_n = WAIT_TICK;
            end
         end
         WAIT_TICK: begin
            if (dsm_tick) begin
               apply   = 1'b1;
               state_n = SETTLE;
            end
         end
         SETTLE: begin
            if (cnt == '0) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // Shadow capture, atomic output update, settle timing and status flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         ch_q         <= 7'd0;
         shadow_frac  <= FRAC_W'(RST_FRAC);
         shadow_const <= CONST_W'(BASE_CONST);
         dsm_in       <= FRAC_W'(RST_FRAC);
         add_const    <= CONST_W'(BASE_CONST);
         cur_ch       <= 7'd0;
         cnt          <= '0;
         settled      <= 1'b0;
         err_range    <= 1'b0;
      end else begin
         err_range <= err_n;
         if (div_start) begin
            ch_q    <= req_ch;
            settled <= 1'b0;
         end
         if (capture) begin
            shadow_frac  <= FRAC_W'(frac_of(div_r));
            shadow_const <= CONST_W'(BASE_CONST) - CONST_W'(div_q);
         end
         if (apply) begin
            dsm_in    <= shadow_frac;
            add_const <= shadow_const;
            cur_ch    <= ch_q;
            cnt       <= CNT_W'(SETTLE_CYC - 1);
         end else if (state == SETTLE) begin
            if (cnt == '0) settled <= 1'b1;
            else            cnt     <= cnt - 1'b1;
         end
      end
   end

   assign req_ready = (state == IDLE);
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_dsm_chan_ctrl.sv
// Bench for dsm_chan_ctrl: expected DSM words pushed on request, popped when applied.
module tb_dsm_chan_ctrl;

   localparam int SETTLE = 16;
   localparam logic [23:0] LUT [10] = '{
      24'h000000, 24'h19999A, 24'h333333, 24'h4CCCCD, 24'h666666,
      24'h800000, 24'h99999A, 24'hB33333, 24'hCCCCCD, 24'hE66666
   };
   localparam logic [38:0] RST_WORD = {7'd0, 8'd16, 24'h333333};

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic [6:0]  req_ch;
   logic        req_ready;
   logic        dsm_tick;
   logic [23:0] dsm_in;
   logic [7:0]  add_const;
   logic [6:0]  cur_ch;
   logic        busy;
   logic        settled;
   logic        err_range;

   always #5 clk = ~clk;

   dsm_chan_ctrl #(.SETTLE_CYC(SETTLE)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ch    (req_ch),
      .req_ready (req_ready),
      .dsm_tick  (dsm_tick),
      .dsm_in    (dsm_in),
      .add_const (add_const),
      .cur_ch    (cur_ch),
      .busy      (busy),
      .settled   (settled),
      .err_range (err_range)
   );

   logic [38:0] out_word;
   assign out_word = {cur_ch, add_const, dsm_in};

   // ---------------- scoreboard ----------------
   int          total = 0;
   int          bad   = 0;
   logic [38:0] exp_q[$];
   logic [38:0] last_word;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [38:0] model(input logic [6:0] ch);
      int n, q, r;
      n = int'(ch) + 2;
      q = n / 10;
      r = n % 10;
      return {ch, 8'(16 - q), LUT[r]};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic tick_clk();
      @(posedge clk);
      #1;
   endtask

   // Hold the request until accepted; waited = cycles spent with req_ready low.
   task automatic send_req(input logic [6:0] ch, output int waited);
      waited    = 0;
      req_valid = 1'b1;
      req_ch    = ch;
      while (!req_ready && waited < 200) begin
         tick_clk();
         waited++;
      end
      if (!req_ready) check_eq("req_timeout", 0, 1);
      tick_clk();
      req_valid = 1'b0;
   endtask

   // Pulse dsm_tick gap cycles after the expected end of CALC and check the apply.
   task automatic tick_pulse(input logic [6:0] ch, input int gap);
      int q;
      logic [38:0] exp_w;
      q = (int'(ch) + 2) / 10;
      repeat (q + 1 + gap) tick_clk();
      check_eq("wait_busy", busy, 1);
      check_eq("pre_tick_hold", out_word, last_word);
      dsm_tick = 1'b1;
      tick_clk();
      dsm_tick = 1'b0;
      if (exp_q.size() == 0) begin
         check_eq("exp_q_empty", 0, 1);
      end else begin
         exp_w = exp_q.pop_front();
         check_eq("apply_word", out_word, exp_w);
         last_word = exp_w;
      end
      check_eq("apply_not_settled", settled, 0);
   endtask

   task automatic settle_phase();
      int cnt;
      cnt = 0;
      while (!settled && cnt < 100) begin
         tick_clk();
         cnt++;
      end
      check_eq("settle_len", cnt, SETTLE);
      check_eq("settle_idle", busy, 0);
      check_eq("settle_ready", req_ready, 1);
   endtask

   // dsm_tick held high from the handshake: latency to settled exposes CALC length.
   task automatic hop_held(input logic [6:0] ch);
      int q, cnt, w;
      logic [38:0] exp_w;
      q = (int'(ch) + 2) / 10;
      exp_q.push_back(model(ch));
      send_req(ch, w);
      dsm_tick = 1'b1;
      cnt = 0;
      while (!settled && cnt < 100) begin
         tick_clk();
         cnt++;
      end
      dsm_tick = 1'b0;
      check_eq("held_latency", cnt, q + 2 + SETTLE);
      if (exp_q.size() == 0) begin
         check_eq("exp_q_empty", 0, 1);
      end else begin
         exp_w = exp_q.pop_front();
         check_eq("held_word", out_word, exp_w);
         last_word = exp_w;
      end
   endtask

   task automatic bad_req(input logic [6:0] ch, input logic exp_settled);
      check_eq("bad_ready", req_ready, 1);
      req_valid = 1'b1;
      req_ch    = ch;
      tick_clk();
      req_valid = 1'b0;
      check_eq("err_pulse", err_range, 1);
      check_eq("err_busy", busy, 0);
      check_eq("err_word", out_word, last_word);
      check_eq("err_settled", settled, exp_settled);
      tick_clk();
      check_eq("err_clear", err_range, 0);
      check_eq("err_busy2", busy, 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int w;
      logic [6:0] ch;
      int gap;
      rst       = 1'b1;
      req_valid = 1'b0;
      req_ch    = 7'd0;
      dsm_tick  = 1'b0;
      last_word = RST_WORD;
      repeat (3) tick_clk();
      rst = 1'b0;
      repeat (5) tick_clk();
      check_eq("rst_word", out_word, RST_WORD);
      check_eq("rst_settled", settled, 0);
      check_eq("rst_ready", req_ready, 1);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_err", err_range, 0);

      // ch 5: tick three cycles after CALC
      exp_q.push_back(model(7'd5));
      send_req(7'd5, w);
      check_eq("calc_busy", busy, 1);
      tick_pulse(7'd5, 3);
      settle_phase();

      // ch 13 then ch 78 with tick held
      hop_held(7'd13);
      hop_held(7'd78);

      // out-of-range requests
      bad_req(7'd79, 1'b1);
      bad_req(7'd127, 1'b1);

      // request held during SETTLE of a previous hop
      exp_q.push_back(model(7'd50));
      send_req(7'd50, w);
      tick_pulse(7'd50, 0);
      exp_q.push_back(model(7'd20));
      send_req(7'd20, w);
      check_eq("hold_wait", w, SETTLE);
      check_eq("hold_cleared", settled, 0);
      tick_pulse(7'd20, 1);
      settle_phase();

      // re-request of the applied channel runs the full sequence
      exp_q.push_back(model(7'd20));
      send_req(7'd20, w);
      check_eq("rereq_busy", busy, 1);
      tick_pulse(7'd20, 0);
      settle_phase();

      // random hops
      for (int i = 0; i < 4; i++) begin
         ch  = 7'($urandom_range(0, 78));
         gap = int'($urandom_range(0, 3));
         exp_q.push_back(model(ch));
         send_req(ch, w);
         tick_pulse(ch, gap);
         settle_phase();
      end

      // reset during WAIT_TICK of ch 40 (q=4 -> 5 CALC cycles)
      send_req(7'd40, w);
      repeat (5) tick_clk();
      check_eq("pre_rst_busy", busy, 1);
      rst = 1'b1;
      tick_clk();
      rst = 1'b0;
      last_word = RST_WORD;
      check_eq("mid_rst_word", out_word, RST_WORD);
      check_eq("mid_rst_busy", busy, 0);
      check_eq("mid_rst_settled", settled, 0);
      check_eq("mid_rst_ready", req_ready, 1);
      dsm_tick = 1'b1;
      tick_clk();
      dsm_tick = 1'b0;
      tick_clk();
      check_eq("late_tick_word", out_word, RST_WORD);
      check_eq("late_tick_busy", busy, 0);

      check_eq("exp_q_drained", exp_q.size(), 0);

      // ---------------- final report ----------------
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/dsm_chan_ctrl.md
Name: dsm_chan_ctrl

Overview:
Channel-hop controller for the fractional-N PLL DSM path. It accepts a channel-change request over a valid/ready handshake and range-checks it. It then derives the integer constant and 24-bit DSM fraction with a multi-cycle divide-by-10, applies both atomically on a DSM update strobe, and times a settle window before reporting the new channel as settled. It sits between the channel-select register interface and the DSM/divider, replacing the combinational channel lookup.

Parameters:
NUM_CH, 79, number of legal channels (0..NUM_CH-1); channel c maps to 240.2 + 0.1*c MHz.
FRAC_W, 24, DSM fraction width.
CONST_W, 8, add_const width.
SETTLE_CYC, 1024, clk cycles held in SETTLE after applying a new word (>=1).
CNT_W, 11, settle counter width; must satisfy 2^CNT_W > SETTLE_CYC.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
req_valid  in  1  channel request valid
req_ch  in  7  requested channel number
req_ready  out  1  controller can accept a request
dsm_tick  in  1  one-cycle DSM update-boundary strobe
dsm_in  out  FRAC_W  DSM fractional input word
add_const  out  CONST_W  divider integer constant
cur_ch  out  7  channel currently applied
busy  out  1  state != IDLE
settled  out  1  applied channel has completed its settle window
err_range  out  1  one-cycle pulse on an out-of-range request

Behaviour:
- One clock; reset is synchronous and active-high. All state updates occur on the rising clk edge.
- Reset values:
  - state=IDLE
  - dsm_in=0x333333, add_const=16, cur_ch=0 (channel 0 = 240.2)
  - settled=0, err_range=0, busy=0
- req_ready = (state==IDLE). A handshake completes when req_valid & req_ready.
- Mapping, with n = c+2, q = n/10, r = n%10:
  - add_const = 16 - q (range 16..8).
  - dsm_in = FRAC_LUT[r], where FRAC_LUT[r] = round(r*2^24/10).
  - FRAC_LUT = 0x000000, 0x19999A, 0x333333, 0x4CCCCD, 0x666666, 0x800000, 0x99999A, 0xB33333, 0xCCCCCD, 0xE66666.
- FSM IDLE:
  - Handshake with req_ch >= NUM_CH: err_range=1 for exactly one cycle; stay in IDLE; outputs and settled unchanged.
  - Legal handshake: latch ch_q=req_ch, n=req_ch+2 (7-bit, max 80), q=0; clear settled; go to CALC.
- FSM CALC (one step per cycle):
  - If n>=10: n-=10, q+=1.
  - Else: shadow_frac=FRAC_LUT[n], shadow_const=16-q; go to WAIT_TICK.
  - CALC occupies q+1 cycles (1..9).
- FSM WAIT_TICK:
  - On dsm_tick=1: in that edge load dsm_in, add_const, cur_ch from the shadow registers together (no partial update), set cnt=SETTLE_CYC-1, go to SETTLE.
  - dsm_tick is ignored in every other state.
- FSM SETTLE:
  - Decrement cnt each cycle.
  - At cnt==0: settled=1 and go to IDLE in the same edge. Total SETTLE dwell is SETTLE_CYC cycles.
- Requests while busy are not accepted: req_ready=0, and the requester must hold req_valid.
- Re-requesting the channel already applied runs the full sequence; it is not short-circuited.
- Reset mid-operation: the next edge restores all reset values; the pending request is discarded.
- Outputs dsm_in, add_const and cur_ch are registered and change only on the WAIT_TICK->SETTLE edge or on reset.

Decomposition:
- Shared package dsm_pkg holds:
  - FRAC_LUT constant array (10 x 24b)
  - BASE_CONST=16
  - RST_FRAC=0x333333
  - state enum {IDLE, CALC, WAIT_TICK, SETTLE}
  - NUM_CH default
- One sub-module, chan_div10: sequential divide-by-10 by repeated subtraction. Interface: start, n_in[6:0]; outputs done, q[3:0], r[3:0].
- Top level keeps the FSM, shadow registers, output registers and settle counter.

Test Plan:
- Reset, then idle 5 cycles -> dsm_in=0x333333, add_const=16, cur_ch=0, settled=0, req_ready=1, busy=0.
- Request ch 5, dsm_tick 3 cycles after leaving CALC, SETTLE_CYC=16 -> CALC 1 cycle; dsm_in=0xB33333, add_const=16, cur_ch=5 on the tick edge; settled=1 exactly 16 cycles later.
- Request ch 13, then ch 78 -> ch 13 gives 0x800000 / 15 with CALC=2 cycles; ch 78 gives 0x000000 / 8 with CALC=9 cycles.
- Request ch 79 and ch 127 -> err_range one-cycle pulse each; no state change; outputs and settled unchanged.
- Hold req_valid with ch 20 while in SETTLE of a previous hop -> req_ready=0 throughout; accepted on the first IDLE cycle; result 0x333333 / 14.
- Assert rst during WAIT_TICK after requesting ch 40 -> next edge: IDLE, reset output values; a later dsm_tick has no effect.
